// File: rtl/hydra_pkg.sv
// Shared parameters and state encoding for the hydra index/mask datapath blocks.
package hydra_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int IDX_W_DEF  = 4;
   localparam int NONE_IDX   = DATA_W_DEF;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } asm_state_t;

endpackage

// File: rtl/popcount.sv
// Combinational population count of a DATA_W-bit vector.
module popcount
   import hydra_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic [DATA_W-1:0] din,
   output logic [IDX_W-1:0]  cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < DATA_W; i++) begin
         cnt = cnt + IDX_W'(din[i]);
      end
   end

endmodule

// File: rtl/one_hot_assembler.sv
// Collects a stream of bit indices into a multi-hot mask and hands it off
// with a valid/ready handshake, flagging repeated and out-of-range indices.
module one_hot_assembler
   import hydra_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  idx,
   input  logic              idx_valid,
   input  logic              idx_last,
   output logic              idx_ready,
   output logic [DATA_W-1:0] mask,
   output logic [IDX_W-1:0]  mask_cnt,
   output logic              mask_valid,
   input  logic              mask_ready,
   output logic              dup,
   output logic              err
);

   localparam logic [IDX_W-1:0] NONE = IDX_W'(DATA_W);

   asm_state_t        state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              dup_q, dup_d;
   logic              err_q, err_d;
   logic              live_q;
   logic              xfer;
   logic [DATA_W-1:0] idx_bit;

   // live_q keeps idx_ready low until the first edge after reset release.
   assign idx_ready  = live_q && (state_q == ACCUM);
   assign mask_valid = (state_q == HOLD);
   assign xfer       = idx_valid && idx_ready;
   assign idx_bit    = (idx < NONE) ? (DATA_W'(1) << idx) : '0;

   // Count the next accumulator value so the count is already in step with
   // the mask on the cycle mask_valid rises.
   popcount #(
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
   ) u_popcount (
      .din(acc_d),
      .cnt(cnt_d)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dup_d   = dup_q;
      err_d   = err_q;
      unique case (state_q)
         ACCUM: begin
            if (xfer) begin
               if (idx > NONE) begin
                  err_d = 1'b1;
               end else if ((acc_q & idx_bit) != '0) begin
                  dup_d = 1'b1;
               end
               acc_d = acc_q | idx_bit;
               if (idx_last) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (mask_ready) begin
               state_d = ACCUM;
               acc_d   = '0;
               dup_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         dup_q   <= 1'b0;
         err_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         dup_q   <= dup_d;
         err_q   <= err_d;
         live_q  <= 1'b1;
      end
   end

   assign mask     = acc_q;
   assign mask_cnt = cnt_q;
   assign dup      = dup_q;
   assign err      = err_q;

endmodule

// File: tb/tb_one_hot_assembler.sv
// Directed bench for one_hot_assembler: hand-computed masks, counts and flags.
module tb_one_hot_assembler;

   logic       clk;
   logic       rst_n;
   logic [3:0] idx;
   logic       idx_valid;
   logic       idx_last;
   logic       idx_ready;
   logic [7:0] mask;
   logic [3:0] mask_cnt;
   logic       mask_valid;
   logic       mask_ready;
   logic       dup;
   logic       err;

   int errors = 0;
   int checks = 0;

   one_hot_assembler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .idx_valid (idx_valid),
      .idx_last  (idx_last),
      .idx_ready (idx_ready),
      .mask      (mask),
      .mask_cnt  (mask_cnt),
      .mask_valid(mask_valid),
      .mask_ready(mask_ready),
      .dup       (dup),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge after the index was taken.
   task automatic applyStimulus(input logic [3:0] i, input logic last);
      int waited = 0;
      while (!idx_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("ready_timeout", 32'(idx_ready), 32'd1);
      idx       = i;
      idx_valid = 1'b1;
      idx_last  = last;
      @(negedge clk);
      idx_valid = 1'b0;
      idx_last  = 1'b0;
   endtask

   task automatic checkMask(input string tag, input logic [7:0] m, input logic [3:0] c,
                            input logic d, input logic e);
      checkOutput({tag, "_valid"}, 32'(mask_valid), 32'd1);
      checkOutput({tag, "_ready"}, 32'(idx_ready), 32'd0);
      checkOutput({tag, "_mask"}, 32'(mask), 32'(m));
      checkOutput({tag, "_cnt"}, 32'(mask_cnt), 32'(c));
      checkOutput({tag, "_dup"}, 32'(dup), 32'(d));
      checkOutput({tag, "_err"}, 32'(err), 32'(e));
   endtask

   task automatic releaseMask(input string tag);
      mask_ready = 1'b1;
      @(negedge clk);
      mask_ready = 1'b0;
      checkOutput({tag, "_clr_valid"}, 32'(mask_valid), 32'd0);
      checkOutput({tag, "_clr_ready"}, 32'(idx_ready), 32'd1);
      checkOutput({tag, "_clr_mask"}, 32'(mask), 32'd0);
      checkOutput({tag, "_clr_cnt"}, 32'(mask_cnt), 32'd0);
      checkOutput({tag, "_clr_flags"}, 32'({dup, err}), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      idx        = '0;
      idx_valid  = 1'b0;
      idx_last   = 1'b0;
      mask_ready = 1'b0;

      #2;
      checkOutput("rst_mask", 32'(mask), 32'd0);
      checkOutput("rst_valid", 32'(mask_valid), 32'd0);
      checkOutput("rst_ready", 32'(idx_ready), 32'd0);
      checkOutput("rst_cnt", 32'(mask_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_ready_early", 32'(idx_ready), 32'd0);
      @(negedge clk);
      checkOutput("rel_ready", 32'(idx_ready), 32'd1);

      applyStimulus(4'd3, 1'b1);
      checkMask("single", 8'b0000_1000, 4'd1, 1'b0, 1'b0);
      releaseMask("single");

      applyStimulus(4'd4, 1'b0);
      applyStimulus(4'd5, 1'b0);
      applyStimulus(4'd6, 1'b0);
      applyStimulus(4'd7, 1'b1);
      checkMask("multi", 8'b1111_0000, 4'd4, 1'b0, 1'b0);
      idx       = 4'd2;
      idx_valid = 1'b1;
      idx_last  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkMask($sformatf("multi_hold%0d", k), 8'b1111_0000, 4'd4, 1'b0, 1'b0);
      end
      idx_valid = 1'b0;
      idx_last  = 1'b0;
      releaseMask("multi");

      applyStimulus(4'd8, 1'b0);
      applyStimulus(4'd0, 1'b1);
      checkMask("edge_none0", 8'b0000_0001, 4'd1, 1'b0, 1'b0);
      releaseMask("edge_none0");

      applyStimulus(4'd12, 1'b1);
      checkMask("edge_over", 8'b0000_0000, 4'd0, 1'b0, 1'b1);
      releaseMask("edge_over");

      applyStimulus(4'd8, 1'b1);
      checkMask("only_none", 8'b0000_0000, 4'd0, 1'b0, 1'b0);
      releaseMask("only_none");

      applyStimulus(4'd1, 1'b0);
      applyStimulus(4'd1, 1'b0);
      applyStimulus(4'd2, 1'b1);
      checkMask("dup", 8'b0000_0110, 4'd2, 1'b1, 1'b0);
      releaseMask("dup");
      applyStimulus(4'd5, 1'b1);
      checkMask("after_dup", 8'b0010_0000, 4'd1, 1'b0, 1'b0);
      releaseMask("after_dup");

      // Back-to-back with the consumer always ready; idx 3 is presented
      // during HOLD and must be taken only once the block returns to ACCUM.
      mask_ready = 1'b1;
      idx        = 4'd0;
      idx_valid  = 1'b1;
      idx_last   = 1'b0;
      @(negedge clk);
      idx      = 4'd7;
      idx_last = 1'b1;
      @(negedge clk);
      checkOutput("b2b_a_valid", 32'(mask_valid), 32'd1);
      checkOutput("b2b_a_mask", 32'(mask), 32'h81);
      checkOutput("b2b_a_cnt", 32'(mask_cnt), 32'd2);
      idx = 4'd3;
      @(negedge clk);
      checkOutput("b2b_gap_valid", 32'(mask_valid), 32'd0);
      checkOutput("b2b_gap_ready", 32'(idx_ready), 32'd1);
      @(negedge clk);
      idx_valid = 1'b0;
      idx_last  = 1'b0;
      checkOutput("b2b_b_valid", 32'(mask_valid), 32'd1);
      checkOutput("b2b_b_mask", 32'(mask), 32'h08);
      checkOutput("b2b_b_cnt", 32'(mask_cnt), 32'd1);
      @(negedge clk);
      checkOutput("b2b_end_valid", 32'(mask_valid), 32'd0);
      checkOutput("b2b_end_mask", 32'(mask), 32'd0);
      mask_ready = 1'b0;

      applyStimulus(4'd2, 1'b1);
      checkMask("pre_rst", 8'b0000_0100, 4'd1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("hold_rst_mask", 32'(mask), 32'd0);
      checkOutput("hold_rst_valid", 32'(mask_valid), 32'd0);
      checkOutput("hold_rst_ready", 32'(idx_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(mask_valid), 32'd0);
      checkOutput("post_rst_ready", 32'(idx_ready), 32'd1);
      checkOutput("post_rst_mask", 32'(mask), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
